// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for a multicycle RISC-V style datapath. It sequences each
// instruction through FETCH -> DECODE -> EXECUTE -> (MEMORY) -> (WRITEBACK).
// It drives the datapath strobes and counts retired instructions. A memory
// access that stalls too long, an illegal opcode, or a corrupt state code
// drops the controller into a sticky ERROR state. Only reset releases it.
//
// Parameters
//   MEM_WAIT_MAX        stalled cycles allowed in FETCH/MEMORY (1..255)
//
// Ports
//   i_clock             rising-edge clock
//   i_reset_n           asynchronous active-low reset
//   i_run               allow issue (sampled in IDLE and at retirement)
//   i_opcode[6:0]       instruction opcode field, sampled in DECODE
//   i_zero              ALU zero flag, used for branch resolution
//   i_mem_ready         memory access completes this cycle
//   o_inst_read_enable  instruction fetch request
//   o_ir_write          load instruction register
//   o_pc_write          update program counter
//   o_branch_taken      PC mux: 1 = branch target, 0 = PC+4
//   o_alu_control[1:0]  00 add, 01 branch compare, 10 R-type, 11 I-type
//   o_imm_enable        ALU operand B = immediate
//   o_mem_read_enable   data memory read strobe
//   o_mem_write_enable  data memory write strobe
//   o_mem_or_alu        writeback select: 1 = memory data
//   o_reg_write_enable  register file write
//   o_state[2:0]        current state encoding
//   o_error             sticky fault flag
//   o_instret[31:0]     retired-instruction counter
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_run,
  input  logic [6:0]  i_opcode,
  input  logic        i_zero,
  input  logic        i_mem_ready,
  output logic        o_inst_read_enable,
  output logic        o_ir_write,
  output logic        o_pc_write,
  output logic        o_branch_taken,
  output logic [1:0]  o_alu_control,
  output logic        o_imm_enable,
  output logic        o_mem_read_enable,
  output logic        o_mem_write_enable,
  output logic        o_mem_or_alu,
  output logic        o_reg_write_enable,
  output logic [2:0]  o_state,
  output logic        o_error,
  output logic [31:0] o_instret
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_ERROR     = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  // Only the five supported instruction classes may proceed to EXECUTE
  function automatic logic is_legal_op(input logic [6:0] op);
    logic legal;
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH: legal = 1'b1;
      default:                                  legal = 1'b0;
    endcase
    return legal;
  endfunction

  state_t      r_state;
  logic [6:0]  r_opcode_q;
  logic [7:0]  r_wait_cnt;
  logic [31:0] r_instret;
  logic        r_error;

  logic        w_op_r;
  logic        w_op_i;
  logic        w_op_load;
  logic        w_op_store;
  logic        w_op_branch;
  logic [7:0]  w_wait_inc;
  logic        w_wait_expired;
  state_t      w_retire_state;

  assign w_op_r      = (r_opcode_q == OP_R);
  assign w_op_i      = (r_opcode_q == OP_I);
  assign w_op_load   = (r_opcode_q == OP_LOAD);
  assign w_op_store  = (r_opcode_q == OP_STORE);
  assign w_op_branch = (r_opcode_q == OP_BRANCH);

  // The current stalled cycle is counted before the limit is compared.
  // The timeout therefore fires on the MEM_WAIT_MAX-th stalled cycle.
  // mem_ready in that same cycle still takes priority.
  assign w_wait_inc     = r_wait_cnt + 8'd1;
  assign w_wait_expired = (w_wait_inc >= WAIT_MAX);
  assign w_retire_state = i_run ? ST_FETCH : ST_IDLE;

  // State sequencing, opcode latch, wait counter, retire counter and fault flag
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_opcode_q <= 7'd0;
      r_wait_cnt <= 8'd0;
      r_instret  <= 32'd0;
      r_error    <= 1'b0;
    end else begin
      // Any cycle that does not stall in FETCH/MEMORY clears the counter.
      // Every entry to a wait state therefore starts from zero.
      r_wait_cnt <= 8'd0;
      case (r_state)
        ST_IDLE: begin
          if (i_run) r_state <= ST_FETCH;
          else       r_state <= ST_IDLE;
        end
        ST_FETCH: begin
          if (i_mem_ready) begin
            r_state <= ST_DECODE;
          end else if (w_wait_expired) begin
            r_state <= ST_ERROR;
            r_error <= 1'b1;
          end else begin
            r_wait_cnt <= w_wait_inc;
          end
        end
        ST_DECODE: begin
          r_opcode_q <= i_opcode;
          if (is_legal_op(i_opcode)) begin
            r_state <= ST_EXECUTE;
          end else begin
            r_state <= ST_ERROR;
            r_error <= 1'b1;
          end
        end
        ST_EXECUTE: begin
          if (w_op_branch) begin
            r_instret <= r_instret + 32'd1;
            r_state   <= w_retire_state;
          end else if (w_op_load || w_op_store) begin
            r_state <= ST_MEMORY;
          end else if (w_op_r || w_op_i) begin
            r_state <= ST_WRITEBACK;
          end else begin
            r_state <= ST_ERROR;
            r_error <= 1'b1;
          end
        end
        ST_MEMORY: begin
          if (i_mem_ready) begin
            if (w_op_store) begin
              r_instret <= r_instret + 32'd1;
              r_state   <= w_retire_state;
            end else begin
              r_state <= ST_WRITEBACK;
            end
          end else if (w_wait_expired) begin
            r_state <= ST_ERROR;
            r_error <= 1'b1;
          end else begin
            r_wait_cnt <= w_wait_inc;
          end
        end
        ST_WRITEBACK: begin
          r_instret <= r_instret + 32'd1;
          r_state   <= w_retire_state;
        end
        ST_ERROR: begin
          r_state <= ST_ERROR;
          r_error <= 1'b1;
        end
        default: begin
          // Unused code 7: treat it as corruption.
          r_state <= ST_ERROR;
          r_error <= 1'b1;
        end
      endcase
    end
  end

  // Datapath strobes decoded from state, latched opcode, zero and mem_ready
  always_comb begin
    o_inst_read_enable = 1'b0;
    o_ir_write         = 1'b0;
    o_pc_write         = 1'b0;
    o_branch_taken     = 1'b0;
    o_alu_control      = 2'b00;
    o_imm_enable       = 1'b0;
    o_mem_read_enable  = 1'b0;
    o_mem_write_enable = 1'b0;
    o_mem_or_alu       = 1'b0;
    o_reg_write_enable = 1'b0;
    case (r_state)
      ST_FETCH: begin
        o_inst_read_enable = 1'b1;
        o_ir_write         = i_mem_ready;
      end
      ST_EXECUTE: begin
        if (w_op_r) begin
          o_alu_control = 2'b10;
        end else if (w_op_i) begin
          o_alu_control = 2'b11;
          o_imm_enable  = 1'b1;
        end else if (w_op_load || w_op_store) begin
          o_alu_control = 2'b00;
          o_imm_enable  = 1'b1;
        end else if (w_op_branch) begin
          o_alu_control  = 2'b01;
          o_pc_write     = 1'b1;
          o_branch_taken = i_zero;
        end else begin
          o_alu_control = 2'b00;
          o_imm_enable  = 1'b0;
        end
      end
      ST_MEMORY: begin
        o_alu_control      = 2'b00;
        o_imm_enable       = 1'b1;
        o_mem_read_enable  = w_op_load;
        o_mem_write_enable = w_op_store;
        o_pc_write         = w_op_store & i_mem_ready;
      end
      ST_WRITEBACK: begin
        o_reg_write_enable = 1'b1;
        o_pc_write         = 1'b1;
        o_mem_or_alu       = w_op_load;
      end
      default: begin
        o_inst_read_enable = 1'b0;
      end
    endcase
  end

  assign o_state   = r_state;
  assign o_error   = r_error;
  assign o_instret = r_instret;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed bench for multicycle_controller. Inputs are driven on the falling
// edge. Outputs are sampled 1 ns later, well away from the rising edge. All
// expected values are hand-derived constants for each scenario.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic        i_run;
  logic [6:0]  i_opcode;
  logic        i_zero;
  logic        i_mem_ready;
  logic        o_inst_read_enable;
  logic        o_ir_write;
  logic        o_pc_write;
  logic        o_branch_taken;
  logic [1:0]  o_alu_control;
  logic        o_imm_enable;
  logic        o_mem_read_enable;
  logic        o_mem_write_enable;
  logic        o_mem_or_alu;
  logic        o_reg_write_enable;
  logic [2:0]  o_state;
  logic        o_error;
  logic [31:0] o_instret;
  logic [11:0] strobes;

  int n_cmp = 0;
  int n_err = 0;

  assign strobes = {o_inst_read_enable, o_ir_write, o_pc_write, o_branch_taken,
                    o_alu_control, o_imm_enable, o_mem_read_enable,
                    o_mem_write_enable, o_mem_or_alu, o_reg_write_enable};

  multicycle_controller #(.MEM_WAIT_MAX(15)) dut (
    .i_clock            (clk),
    .i_reset_n          (i_reset_n),
    .i_run              (i_run),
    .i_opcode           (i_opcode),
    .i_zero             (i_zero),
    .i_mem_ready        (i_mem_ready),
    .o_inst_read_enable (o_inst_read_enable),
    .o_ir_write         (o_ir_write),
    .o_pc_write         (o_pc_write),
    .o_branch_taken     (o_branch_taken),
    .o_alu_control      (o_alu_control),
    .o_imm_enable       (o_imm_enable),
    .o_mem_read_enable  (o_mem_read_enable),
    .o_mem_write_enable (o_mem_write_enable),
    .o_mem_or_alu       (o_mem_or_alu),
    .o_reg_write_enable (o_reg_write_enable),
    .o_state            (o_state),
    .o_error            (o_error),
    .o_instret          (o_instret)
  );

  always #5 clk = ~clk;

  // Return to IDLE: hold reset low one cycle and release it on a falling edge
  task automatic do_reset();
    i_reset_n   = 1'b0;
    i_run       = 1'b0;
    i_opcode    = 7'd0;
    i_zero      = 1'b0;
    i_mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    i_run = 1'b1; i_opcode = OP_R; i_zero = 1'b0; i_mem_ready = 1'b1;
    i_reset_n = 1'b1;
    #2;
    i_reset_n = 1'b0;
    #1;
    n_cmp++; if ({o_state, o_error} !== {3'd0, 1'b0}) begin n_err++; $display("FAIL reset_state: got state=%0d err=%b, want state=0 err=0", o_state, o_error); end
    n_cmp++; if (o_instret !== 32'd0) begin n_err++; $display("FAIL reset_instret: got %0d, want 0", o_instret); end
    n_cmp++; if (strobes !== 12'd0) begin n_err++; $display("FAIL reset_strobes: got %b, want 0", strobes); end
    i_run = 1'b0;
    @(negedge clk);
    i_reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++; if ({o_state, strobes} !== {3'd0, 12'd0}) begin n_err++; $display("FAIL reset_idle_hold: got state=%0d strobes=%b, want 0/0", o_state, strobes); end
  endtask

  // R-type followed directly by an I-type; mem_ready stays high throughout
  task automatic test_back_to_back();
    do_reset();
    i_opcode = OP_R; i_run = 1'b1; i_mem_ready = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 5) begin i_opcode = OP_I; i_run = 1'b0; end
      #1;
      case (c)
        1: begin n_cmp++; if ({o_state, o_inst_read_enable, o_ir_write} !== {3'd1, 1'b1, 1'b1}) begin n_err++; $display("FAIL rtype_fetch: got st=%0d ire=%b irw=%b, want 1/1/1", o_state, o_inst_read_enable, o_ir_write); end end
        2: begin n_cmp++; if (o_state !== 3'd2) begin n_err++; $display("FAIL rtype_decode: got %0d, want 2", o_state); end end
        3: begin n_cmp++; if ({o_state, o_alu_control, o_imm_enable} !== {3'd3, 2'b10, 1'b0}) begin n_err++; $display("FAIL rtype_exec: got st=%0d alu=%b imm=%b, want 3/10/0", o_state, o_alu_control, o_imm_enable); end end
        4: begin n_cmp++; if ({o_state, o_reg_write_enable, o_pc_write, o_branch_taken, o_mem_or_alu} !== {3'd5, 1'b1, 1'b1, 1'b0, 1'b0}) begin n_err++; $display("FAIL rtype_wb: got st=%0d rw=%b pc=%b bt=%b moa=%b, want 5/1/1/0/0", o_state, o_reg_write_enable, o_pc_write, o_branch_taken, o_mem_or_alu); end end
        5: begin n_cmp++; if ({o_state, o_instret} !== {3'd1, 32'd1}) begin n_err++; $display("FAIL rtype_retire: got st=%0d instret=%0d, want 1/1", o_state, o_instret); end end
        7: begin n_cmp++; if ({o_state, o_alu_control, o_imm_enable} !== {3'd3, 2'b11, 1'b1}) begin n_err++; $display("FAIL itype_exec: got st=%0d alu=%b imm=%b, want 3/11/1", o_state, o_alu_control, o_imm_enable); end end
        8: begin n_cmp++; if ({o_state, o_reg_write_enable, o_mem_or_alu} !== {3'd5, 1'b1, 1'b0}) begin n_err++; $display("FAIL itype_wb: got st=%0d rw=%b moa=%b, want 5/1/0", o_state, o_reg_write_enable, o_mem_or_alu); end end
        9: begin n_cmp++; if ({o_state, o_instret} !== {3'd0, 32'd2}) begin n_err++; $display("FAIL itype_idle: got st=%0d instret=%0d, want 0/2", o_state, o_instret); end end
        default: ;
      endcase
    end
  endtask

  // Load with three stalled MEMORY cycles; the load should be busy 8 cycles
  task automatic test_load_wait();
    int busy;
    int rd_cnt;
    do_reset();
    i_opcode = OP_LOAD; i_run = 1'b1; i_mem_ready = 1'b1;
    busy = 0; rd_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      i_run = 1'b0;
      i_mem_ready = (c >= 4 && c <= 6) ? 1'b0 : 1'b1;
      #1;
      if (o_state == 3'd0) break;
      busy++;
      if (o_mem_read_enable) rd_cnt++;
      if (o_state == 3'd3) begin n_cmp++; if ({o_alu_control, o_imm_enable} !== {2'b00, 1'b1}) begin n_err++; $display("FAIL load_exec: got alu=%b imm=%b, want 00/1", o_alu_control, o_imm_enable); end end
      if (o_state == 3'd5) begin n_cmp++; if ({o_mem_or_alu, o_reg_write_enable, o_pc_write} !== 3'b111) begin n_err++; $display("FAIL load_wb: got moa=%b rw=%b pc=%b, want 1/1/1", o_mem_or_alu, o_reg_write_enable, o_pc_write); end end
    end
    n_cmp++; if (busy !== 8) begin n_err++; $display("FAIL load_latency: got %0d cycles, want 8", busy); end
    n_cmp++; if (rd_cnt !== 4) begin n_err++; $display("FAIL load_read_cycles: got %0d, want 4", rd_cnt); end
    n_cmp++; if (o_instret !== 32'd1) begin n_err++; $display("FAIL load_instret: got %0d, want 1", o_instret); end
  endtask

  // Two branches back to back: taken (zero=1), then not taken (zero=0)
  task automatic test_branch();
    logic rw_seen;
    do_reset();
    i_opcode = OP_BRANCH; i_run = 1'b1; i_mem_ready = 1'b1; i_zero = 1'b1;
    rw_seen = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      i_zero = (c <= 3) ? 1'b1 : 1'b0;
      i_run  = (c <= 3) ? 1'b1 : 1'b0;
      #1;
      if (o_reg_write_enable) rw_seen = 1'b1;
      case (c)
        3: begin n_cmp++; if ({o_state, o_pc_write, o_branch_taken, o_alu_control, o_imm_enable} !== {3'd3, 1'b1, 1'b1, 2'b01, 1'b0}) begin n_err++; $display("FAIL branch_taken: got st=%0d pc=%b bt=%b alu=%b imm=%b, want 3/1/1/01/0", o_state, o_pc_write, o_branch_taken, o_alu_control, o_imm_enable); end end
        4: begin n_cmp++; if ({o_state, o_instret} !== {3'd1, 32'd1}) begin n_err++; $display("FAIL branch_retire: got st=%0d instret=%0d, want 1/1", o_state, o_instret); end end
        6: begin n_cmp++; if ({o_state, o_pc_write, o_branch_taken, o_alu_control} !== {3'd3, 1'b1, 1'b0, 2'b01}) begin n_err++; $display("FAIL branch_not_taken: got st=%0d pc=%b bt=%b alu=%b, want 3/1/0/01", o_state, o_pc_write, o_branch_taken, o_alu_control); end end
        7: begin n_cmp++; if ({o_state, o_instret} !== {3'd0, 32'd2}) begin n_err++; $display("FAIL branch_idle: got st=%0d instret=%0d, want 0/2", o_state, o_instret); end end
        default: ;
      endcase
    end
    n_cmp++; if (rw_seen !== 1'b0) begin n_err++; $display("FAIL branch_regwrite: got %b, want 0", rw_seen); end
  endtask

  // Zero-wait store retiring from MEMORY, then a store stalled forever in MEMORY
  task automatic test_store();
    int mem_cycles;
    do_reset();
    i_opcode = OP_STORE; i_run = 1'b1; i_mem_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      i_run = 1'b0;
      #1;
      case (c)
        3: begin n_cmp++; if ({o_state, o_alu_control, o_imm_enable} !== {3'd3, 2'b00, 1'b1}) begin n_err++; $display("FAIL store_exec: got st=%0d alu=%b imm=%b, want 3/00/1", o_state, o_alu_control, o_imm_enable); end end
        4: begin n_cmp++; if ({o_state, o_mem_write_enable, o_mem_read_enable, o_pc_write, o_branch_taken, o_reg_write_enable} !== {3'd4, 5'b10100}) begin n_err++; $display("FAIL store_mem: got st=%0d we=%b re=%b pc=%b bt=%b rw=%b, want 4/1/0/1/0/0", o_state, o_mem_write_enable, o_mem_read_enable, o_pc_write, o_branch_taken, o_reg_write_enable); end end
        5: begin n_cmp++; if ({o_state, o_instret} !== {3'd0, 32'd1}) begin n_err++; $display("FAIL store_retire: got st=%0d instret=%0d, want 0/1", o_state, o_instret); end end
        default: ;
      endcase
    end
    // Fetch stalls 5 cycles first, so the MEMORY timeout must restart from zero
    do_reset();
    i_opcode = OP_STORE; i_run = 1'b1; i_mem_ready = 1'b0;
    mem_cycles = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      i_mem_ready = (c >= 6 && c <= 8) ? 1'b1 : 1'b0;
      #1;
      if (o_state == 3'd4) mem_cycles++;
      else if (c > 8) break;
    end
    n_cmp++; if (mem_cycles !== 15) begin n_err++; $display("FAIL mem_timeout_len: got %0d, want 15", mem_cycles); end
    n_cmp++; if ({o_state, o_error, strobes} !== {3'd6, 1'b1, 12'd0}) begin n_err++; $display("FAIL mem_timeout_err: got st=%0d err=%b strobes=%b, want 6/1/0", o_state, o_error, strobes); end
  endtask

  // Illegal opcode traps after DECODE; the fault is sticky until reset
  task automatic test_illegal();
    int bad;
    do_reset();
    i_opcode = 7'b1111111; i_run = 1'b1; i_mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    n_cmp++; if (o_state !== 3'd2) begin n_err++; $display("FAIL illegal_decode: got %0d, want 2", o_state); end
    @(negedge clk); #1;
    n_cmp++; if ({o_state, o_error} !== {3'd6, 1'b1}) begin n_err++; $display("FAIL illegal_trap: got st=%0d err=%b, want 6/1", o_state, o_error); end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (o_state !== 3'd6 || o_error !== 1'b1 || strobes !== 12'd0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL illegal_sticky: got %0d bad cycles, want 0", bad); end
    #2;
    i_reset_n = 1'b0;
    #1;
    n_cmp++; if ({o_state, o_error, o_instret} !== {3'd0, 1'b0, 32'd0}) begin n_err++; $display("FAIL illegal_reset: got st=%0d err=%b instret=%0d, want 0/0/0", o_state, o_error, o_instret); end
    @(negedge clk);
    i_reset_n = 1'b1;
  endtask

  // Fetch timeout on the 15th stalled cycle; a late ready on that cycle wins
  task automatic test_fetch_timeout();
    int fetch_cycles;
    int bad;
    do_reset();
    i_opcode = OP_R; i_run = 1'b1; i_mem_ready = 1'b0;
    fetch_cycles = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk); #1;
      if (o_state == 3'd1) fetch_cycles++;
      else break;
    end
    n_cmp++; if (fetch_cycles !== 15) begin n_err++; $display("FAIL fetch_timeout_len: got %0d, want 15", fetch_cycles); end
    n_cmp++; if ({o_state, o_error} !== {3'd6, 1'b1}) begin n_err++; $display("FAIL fetch_timeout_err: got st=%0d err=%b, want 6/1", o_state, o_error); end
    do_reset();
    i_opcode = OP_R; i_run = 1'b1; i_mem_ready = 1'b0;
    bad = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      i_mem_ready = (c == 15) ? 1'b1 : 1'b0;
      #1;
      if (o_state !== 3'd1) bad++;
    end
    @(negedge clk); #1;
    n_cmp++; if ({o_state, o_error, bad} !== {3'd2, 1'b0, 32'd0}) begin n_err++; $display("FAIL fetch_late_ready: got st=%0d err=%b bad=%0d, want 2/0/0", o_state, o_error, bad); end
  endtask

  // Reset asserted between clock edges while a store is stalled in MEMORY
  task automatic test_store_reset();
    do_reset();
    i_opcode = OP_STORE; i_run = 1'b1; i_mem_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      i_mem_ready = (c <= 3) ? 1'b1 : 1'b0;
    end
    #1;
    n_cmp++; if ({o_state, o_mem_write_enable} !== {3'd4, 1'b1}) begin n_err++; $display("FAIL store_stall: got st=%0d we=%b, want 4/1", o_state, o_mem_write_enable); end
    #2;
    i_reset_n = 1'b0;
    #1;
    n_cmp++; if ({o_state, o_mem_write_enable, o_instret, strobes} !== {3'd0, 1'b0, 32'd0, 12'd0}) begin n_err++; $display("FAIL store_async_reset: got st=%0d we=%b instret=%0d strobes=%b, want 0/0/0/0", o_state, o_mem_write_enable, o_instret, strobes); end
    i_run = 1'b0;
    @(negedge clk);
    i_reset_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if ({o_state, strobes} !== {3'd0, 12'd0}) begin n_err++; $display("FAIL store_release: got st=%0d strobes=%b, want 0/0", o_state, strobes); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_wait();
    test_branch();
    test_store();
    test_illegal();
    test_fetch_timeout();
    test_store_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: MEM_WAIT_MAX, 15, maximum cycles waiting for mem_ready in FETCH or MEMORY before ERROR; legal range 1-255.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  enables instruction issue; sampled in IDLE and at retirement.
REQ-005 opcode  input  7  instruction[6:0] from the instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory access complete (instruction or data) this cycle.
REQ-008 inst_read_enable  output  1  instruction fetch request.
REQ-009 ir_write  output  1  load instruction register.
REQ-010 pc_write  output  1  update program counter.
REQ-011 branch_taken  output  1  PC mux select: 1 = branch target, 0 = PC+4.
REQ-012 alu_control  output  2  00 add (load/store), 01 branch compare, 10 R-type, 11 I-type ALU.
REQ-013 imm_enable  output  1  ALU operand B = immediate.
REQ-014 mem_read_enable / mem_write_enable  output  1 each  data memory strobes.
REQ-015 mem_or_alu  output  1  writeback select: 1 = memory data.
REQ-016 reg_write_enable  output  1  register file write.
REQ-017 state  output  3  current state encoding.
REQ-018 error  output  1  sticky fault flag.
REQ-019 instret  output  32  retired-instruction counter.

Function
REQ-020 States SHALL be encoded as IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, ERROR=6; code 7 SHALL transition to ERROR.
REQ-021 Outputs SHALL be decoded combinationally from the state register, latched opcode_q, and the inputs zero and mem_ready only.
REQ-022 IDLE: all strobes 0; run=1 -> FETCH.
REQ-023 FETCH: inst_read_enable=1; mem_ready=1 -> ir_write=1 for that cycle, then DECODE.
REQ-024 DECODE: opcode SHALL be latched into opcode_q; 0110011, 0010011, 0000011, 0100011 and 1100011 -> EXECUTE; any other value -> ERROR.
REQ-025 EXECUTE: alu_control and imm_enable SHALL follow REQ-012 (imm_enable=1 for I-type, load and store). Next state: R/I -> WRITEBACK; load/store -> MEMORY; branch -> retire with pc_write=1, branch_taken=zero.
REQ-026 MEMORY: alu_control=00, imm_enable=1. Load holds mem_read_enable=1 and store holds mem_write_enable=1 until mem_ready=1; then load -> WRITEBACK, store -> retire with pc_write=1, branch_taken=0.
REQ-027 WRITEBACK: reg_write_enable=1 and pc_write=1 (branch_taken=0) for exactly one cycle; mem_or_alu=1 only for load; then retire.
REQ-028 Retire SHALL increment instret by 1 (wrapping 0xFFFFFFFF -> 0) and go to FETCH if run=1, else IDLE.
REQ-029 An 8-bit wait counter SHALL clear on entry to FETCH/MEMORY and increment each cycle mem_ready=0; reaching MEM_WAIT_MAX SHALL force ERROR on the next edge.
REQ-030 mem_ready arriving in the same cycle the counter reaches MEM_WAIT_MAX SHALL win (normal transition).
REQ-031 ERROR: all strobes and pc_write 0, error=1, held until reset; run ignored.
REQ-032 mem_ready outside FETCH/MEMORY SHALL be ignored.
REQ-033 Latency per instruction with zero-wait memory: branch 3, R/I 4, store 4, load 5 cycles.

Reset
REQ-034 reset=0 SHALL immediately force state=IDLE, opcode_q=0, wait counter=0, instret=0, error=0, all outputs 0, including mid-access; release SHALL be followed by IDLE with no output glitch.

Verification
REQ-035 run=1, mem_ready=1 always, opcode 0110011 -> states 1,2,3,5,1; reg_write_enable and pc_write 1 in cycle 4; instret=1.
REQ-036 Load 0000011, mem_ready low 3 cycles in MEMORY -> mem_read_enable high 4 cycles, mem_or_alu=1 in WRITEBACK, total 8 cycles.
REQ-037 Branch 1100011 with zero=1 then zero=0 -> pc_write=1 with branch_taken=1, then branch_taken=0; reg_write_enable never 1.
REQ-038 Opcode 1111111 -> ERROR after DECODE, error=1 sticky for 20 cycles with run=1; reset=0 clears to IDLE.
REQ-039 mem_ready held 0 in FETCH -> ERROR after 15 cycles; with mem_ready=1 on the 15th cycle -> DECODE.
REQ-040 reset=0 asserted mid-MEMORY store -> mem_write_enable drops asynchronously, instret unchanged at 0.
